fpu_norm_sched: RTL and testbench

//  Shares the single combinational FPU normalizer between the FADD and FMUL result paths.

---
 rtl/fpu_pkg.sv | 20 ++
 rtl/fpu_norm_sched_rr_arb2.sv | 41 ++++
 rtl/fpu_norm_sched.sv | 197 +++++++++++++++++++
 tb/tb_fpu_norm_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: default widths, source encoding and the result record.
package fpu_pkg;

    localparam int MAN_W_DEF = 49;
    localparam int EXP_W_DEF = 9;
    localparam int TAG_W_DEF = 5;

    // Result source: FADD path or FMUL path
    localparam logic SRC_ADD = 1'b0;
    localparam logic SRC_MUL = 1'b1;

    typedef struct packed {
        logic                 sign;
        logic [MAN_W_DEF-1:0] man;
        logic [EXP_W_DEF-1:0] exp;
        logic [TAG_W_DEF-1:0] tag;
        logic                 src;
    } result_t;

endpackage

// File: rtl/fpu_norm_sched_rr_arb2.sv
// Two-way round-robin arbiter. Request/grant bit 0 is FADD, bit 1 is FMUL.
// The last-grant pointer only moves when the grant is actually accepted.
module rr_arb2
    import fpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    // Grant: a lone requester wins; on a tie the side not granted last time wins
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = (last_q == SRC_MUL) ? 2'b01 : 2'b10;
        end
    end

    // Pointer next-state: update only when a grant is consumed
    always_comb begin
        last_d = last_q;
        if (accept_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1] ? SRC_MUL : SRC_ADD;
        end
    end

    // Pointer register; resets to FMUL so FADD wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= SRC_MUL;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/fpu_norm_sched.sv
// Shares one external combinational normalizer between the FADD and FMUL
// result paths: arbitrate -> stage-1 operand reg -> normalizer -> result reg.
// Also accumulates sticky overflow/underflow flags for fcsr.
module fpu_norm_sched
    import fpu_pkg::*;
#(
    parameter int MAN_W = MAN_W_DEF,
    parameter int EXP_W = EXP_W_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             add_valid,
    output logic             add_ready,
    input  logic             add_sign,
    input  logic [MAN_W-1:0] add_man,
    input  logic [EXP_W-1:0] add_exp,
    input  logic [TAG_W-1:0] add_tag,
    input  logic             mul_valid,
    output logic             mul_ready,
    input  logic             mul_sign,
    input  logic [MAN_W-1:0] mul_man,
    input  logic [EXP_W-1:0] mul_exp,
    input  logic [TAG_W-1:0] mul_tag,
    output logic             norm_sign,
    output logic [MAN_W-1:0] norm_man,
    output logic [EXP_W-1:0] norm_exp,
    output logic             norm_done,
    input  logic             norm_res_sign,
    input  logic [MAN_W-1:0] norm_res_man,
    input  logic [EXP_W-1:0] norm_res_exp,
    input  logic             norm_ovf,
    input  logic             norm_unf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_src,
    output logic             out_sign,
    output logic [MAN_W-1:0] out_man,
    output logic [EXP_W-1:0] out_exp,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ovf,
    output logic             out_unf,
    input  logic             flags_clr,
    output logic             sticky_ovf,
    output logic             sticky_unf,
    output logic             busy
);

    logic             adv2, s1_free, acc;
    logic [1:0]       gnt;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_sign_q,  s1_sign_d;
    logic [MAN_W-1:0] s1_man_q,   s1_man_d;
    logic [EXP_W-1:0] s1_exp_q,   s1_exp_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
    logic             s1_src_q,   s1_src_d;

    logic             o_valid_q,  o_valid_d;
    logic             o_sign_q,   o_sign_d;
    logic [MAN_W-1:0] o_man_q,    o_man_d;
    logic [EXP_W-1:0] o_exp_q,    o_exp_d;
    logic [TAG_W-1:0] o_tag_q,    o_tag_d;
    logic             o_src_q,    o_src_d;
    logic             o_ovf_q,    o_ovf_d;
    logic             o_unf_q,    o_unf_d;

    logic             sticky_ovf_q, sticky_ovf_d;
    logic             sticky_unf_q, sticky_unf_d;

    // Pipeline flow control: the result reg drains on out_ready, stage 1 frees behind it
    always_comb begin
        adv2    = !o_valid_q || out_ready;
        s1_free = !s1_valid_q || adv2;
    end

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    ({mul_valid, add_valid}),
        .accept_i (s1_free && !rst),
        .gnt_o    (gnt)
    );

    // Readies are held low during reset so no requester believes it was accepted
    assign add_ready = s1_free && gnt[0] && !rst;
    assign mul_ready = s1_free && gnt[1] && !rst;
    assign acc       = add_ready || mul_ready;

    // Stage 1 next-state: capture the granted operand whenever the stage is free
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_man_d   = s1_man_q;
        s1_exp_d   = s1_exp_q;
        s1_tag_d   = s1_tag_q;
        s1_src_d   = s1_src_q;
        if (s1_free) begin
            s1_valid_d = acc;
        end
        if (acc) begin
            s1_sign_d = gnt[1] ? mul_sign : add_sign;
            s1_man_d  = gnt[1] ? mul_man  : add_man;
            s1_exp_d  = gnt[1] ? mul_exp  : add_exp;
            s1_tag_d  = gnt[1] ? mul_tag  : add_tag;
            s1_src_d  = gnt[1] ? SRC_MUL  : SRC_ADD;
        end
    end

    // Stage 2 next-state: register normalizer output; data holds when nothing moves in
    always_comb begin
        o_valid_d = o_valid_q;
        o_sign_d  = o_sign_q;
        o_man_d   = o_man_q;
        o_exp_d   = o_exp_q;
        o_tag_d   = o_tag_q;
        o_src_d   = o_src_q;
        o_ovf_d   = o_ovf_q;
        o_unf_d   = o_unf_q;
        if (adv2) begin
            o_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                o_sign_d = norm_res_sign;
                o_man_d  = norm_res_man;
                o_exp_d  = norm_res_exp;
                o_tag_d  = s1_tag_q;
                o_src_d  = s1_src_q;
                o_ovf_d  = norm_ovf;
                o_unf_d  = norm_unf;
            end
        end
    end

    // Sticky flags: a flag raised by a result entering the out reg beats a clear
    always_comb begin
        sticky_ovf_d = (adv2 && s1_valid_q && norm_ovf) || (sticky_ovf_q && !flags_clr);
        sticky_unf_d = (adv2 && s1_valid_q && norm_unf) || (sticky_unf_q && !flags_clr);
    end

    // State registers; reset drops any in-flight operation and zeroes the data
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_man_q     <= '0;
            s1_exp_q     <= '0;
            s1_tag_q     <= '0;
            s1_src_q     <= SRC_ADD;
            o_valid_q    <= 1'b0;
            o_sign_q     <= 1'b0;
            o_man_q      <= '0;
            o_exp_q      <= '0;
            o_tag_q      <= '0;
            o_src_q      <= SRC_ADD;
            o_ovf_q      <= 1'b0;
            o_unf_q      <= 1'b0;
            sticky_ovf_q <= 1'b0;
            sticky_unf_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_man_q     <= s1_man_d;
            s1_exp_q     <= s1_exp_d;
            s1_tag_q     <= s1_tag_d;
            s1_src_q     <= s1_src_d;
            o_valid_q    <= o_valid_d;
            o_sign_q     <= o_sign_d;
            o_man_q      <= o_man_d;
            o_exp_q      <= o_exp_d;
            o_tag_q      <= o_tag_d;
            o_src_q      <= o_src_d;
            o_ovf_q      <= o_ovf_d;
            o_unf_q      <= o_unf_d;
            sticky_ovf_q <= sticky_ovf_d;
            sticky_unf_q <= sticky_unf_d;
        end
    end

    assign norm_sign  = s1_sign_q;
    assign norm_man   = s1_man_q;
    assign norm_exp   = s1_exp_q;
    assign norm_done  = s1_valid_q;

    assign out_valid  = o_valid_q;
    assign out_sign   = o_sign_q;
    assign out_man    = o_man_q;
    assign out_exp    = o_exp_q;
    assign out_tag    = o_tag_q;
    assign out_src    = o_src_q;
    assign out_ovf    = o_ovf_q;
    assign out_unf    = o_unf_q;

    assign sticky_ovf = sticky_ovf_q;
    assign sticky_unf = sticky_unf_q;
    assign busy       = s1_valid_q || o_valid_q;

endmodule

// File: tb/tb_fpu_norm_sched.sv
// Scoreboard bench for fpu_norm_sched with a behavioural normalizer and
// a transaction-level model of arbitration, occupancy and sticky flags.
module tb_fpu_norm_sched;
    import fpu_pkg::*;

    localparam int MAN_W = 49;
    localparam int EXP_W = 9;
    localparam int TAG_W = 5;

    typedef struct packed {
        logic             sign;
        logic [MAN_W-1:0] man;
        logic [EXP_W-1:0] exp;
        logic [TAG_W-1:0] tag;
    } op_t;

    typedef struct packed {
        logic [MAN_W-1:0] man;
        logic [EXP_W-1:0] exp;
        logic             ovf;
        logic             unf;
    } nres_t;

    typedef struct packed {
        result_t r;
        logic    ovf;
        logic    unf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, add_valid, add_ready, add_sign, mul_valid, mul_ready, mul_sign;
    logic [MAN_W-1:0] add_man, mul_man, norm_man, norm_res_man, out_man;
    logic [EXP_W-1:0] add_exp, mul_exp, norm_exp, norm_res_exp, out_exp;
    logic [TAG_W-1:0] add_tag, mul_tag, out_tag;
    logic             norm_sign, norm_done, norm_res_sign, norm_ovf, norm_unf;
    logic             out_valid, out_ready, out_src, out_sign, out_ovf, out_unf;
    logic             flags_clr, sticky_ovf, sticky_unf, busy;

    fpu_norm_sched #(.MAN_W(MAN_W), .EXP_W(EXP_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .add_valid(add_valid), .add_ready(add_ready), .add_sign(add_sign),
        .add_man(add_man), .add_exp(add_exp), .add_tag(add_tag),
        .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_sign(mul_sign),
        .mul_man(mul_man), .mul_exp(mul_exp), .mul_tag(mul_tag),
        .norm_sign(norm_sign), .norm_man(norm_man), .norm_exp(norm_exp), .norm_done(norm_done),
        .norm_res_sign(norm_res_sign), .norm_res_man(norm_res_man), .norm_res_exp(norm_res_exp),
        .norm_ovf(norm_ovf), .norm_unf(norm_unf),
        .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src), .out_sign(out_sign),
        .out_man(out_man), .out_exp(out_exp), .out_tag(out_tag), .out_ovf(out_ovf), .out_unf(out_unf),
        .flags_clr(flags_clr), .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf), .busy(busy)
    );

    // Behavioural normalizer: hidden bit at MAN_W-2, carry bit shifts right once
    function automatic nres_t tb_norm(input logic [MAN_W-1:0] m, input logic [EXP_W-1:0] e);
        nres_t r;
        int ex;
        logic [MAN_W-1:0] mm;
        mm = m;
        ex = int'(e);
        if (mm == '0) begin
            r.man = '0; r.exp = e; r.ovf = 1'b0; r.unf = 1'b0;
            return r;
        end
        if (mm[MAN_W-1]) begin
            mm = mm >> 1;
            ex = ex + 1;
        end else begin
            for (int i = 0; i < MAN_W && !mm[MAN_W-2]; i++) begin
                mm = mm << 1;
                ex = ex - 1;
            end
        end
        r.man = mm;
        r.ovf = (ex >= 255);
        r.unf = (ex <= 0);
        r.exp = r.unf ? '0 : ex[EXP_W-1:0];
        return r;
    endfunction

    nres_t nr;
    always_comb begin
        nr            = tb_norm(norm_man, norm_exp);
        norm_res_sign = norm_sign;
        norm_res_man  = nr.man;
        norm_res_exp  = nr.exp;
        norm_ovf      = nr.ovf;
        norm_unf      = nr.unf;
    end

    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;
    exp_t sbq[$];

    task automatic chk1(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got=%b want=%b", name, $time, act, req);
        end
    endtask

    task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, req);
        end
    endtask

    function automatic exp_t make_exp(input op_t op, input logic src);
        exp_t  e;
        nres_t n;
        n       = tb_norm(op.man, op.exp);
        e.r.sign = op.sign;
        e.r.man  = n.man;
        e.r.exp  = n.exp;
        e.r.tag  = op.tag;
        e.r.src  = src;
        e.ovf    = n.ovf;
        e.unf    = n.unf;
        return e;
    endfunction

    // Transaction-level model state
    bit   m_s1 = 0, m_o = 0, m_last = 1, m_sov = 0, m_sun = 0;
    exp_t m_s1_item;

    // One clock of stimulus: drive, check against model, then advance model
    task automatic cyc(input logic av, input logic mv, input op_t aop, input op_t mop,
                       input logic ordy, input logic fclr, input logic r);
        int   g;
        bit   adv2, free, set_o, set_u;
        exp_t it;
        @(negedge clk);
        rst = r; add_valid = av; mul_valid = mv; out_ready = ordy; flags_clr = fclr;
        {add_sign, add_man, add_exp, add_tag} = aop;
        {mul_sign, mul_man, mul_exp, mul_tag} = mop;
        #1;
        adv2 = !m_o || ordy;
        free = !m_s1 || adv2;
        if (av && mv)  g = m_last ? 0 : 1;
        else if (av)   g = 0;
        else if (mv)   g = 1;
        else           g = -1;
        if (chk_en) begin
            chk1("add_ready",  add_ready,  !r && free && g == 0);
            chk1("mul_ready",  mul_ready,  !r && free && g == 1);
            chk1("out_valid",  out_valid,  m_o);
            chk1("norm_done",  norm_done,  m_s1);
            chk1("busy",       busy,       m_s1 || m_o);
            chk1("sticky_ovf", sticky_ovf, m_sov);
            chk1("sticky_unf", sticky_unf, m_sun);
        end
        if (r) begin
            m_s1 = 0; m_o = 0; m_last = 1; m_sov = 0; m_sun = 0;
            sbq.delete();
        end else begin
            set_o = adv2 && m_s1 && m_s1_item.ovf;
            set_u = adv2 && m_s1 && m_s1_item.unf;
            m_sov = set_o || (m_sov && !fclr);
            m_sun = set_u || (m_sun && !fclr);
            if (adv2) m_o = m_s1;
            if (free) begin
                m_s1 = (g >= 0);
                if (g >= 0) begin
                    it = make_exp(g == 0 ? aop : mop, g == 0 ? SRC_ADD : SRC_MUL);
                    m_s1_item = it;
                    sbq.push_back(it);
                    m_last = (g == 1);
                end
            end
        end
    endtask

    function automatic op_t rnd_op();
        op_t         o;
        logic [63:0] w;
        w     = {$urandom, $urandom};
        o.sign = w[63];
        o.man  = w[MAN_W-1:0] >> $urandom_range(0, MAN_W);
        o.exp  = EXP_W'($urandom_range(0, 511));
        o.tag  = TAG_W'($urandom_range(0, 31));
        return o;
    endfunction

    // Monitor: pops the scoreboard on each output handshake, checks hold under backpressure
    initial begin
        exp_t          e;
        bit            hold = 0;
        logic [127:0]  saved = '0;
        logic [127:0]  cur;
        forever begin
            @(negedge clk);
            #2;
            cur = 128'({out_sign, out_man, out_exp, out_tag, out_src, out_ovf, out_unf});
            if (chk_en && hold) chkw("out_hold", cur, saved);
            hold  = chk_en && out_valid && !out_ready && !rst;
            saved = cur;
            if (chk_en && out_valid && out_ready && !rst) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL out_extra at %0t: got=%h want=none", $time, cur);
                end else begin
                    e = sbq.pop_front();
                    chkw("out_data", cur, 128'(e));
                end
            end
        end
    end

    initial begin
        op_t z, a, m;
        z = '0;
        rst = 1; add_valid = 0; mul_valid = 0; out_ready = 1; flags_clr = 0;
        {add_sign, add_man, add_exp, add_tag} = z;
        {mul_sign, mul_man, mul_exp, mul_tag} = z;

        // Reset for two cycles, then idle
        cyc(0, 0, z, z, 1, 0, 1);
        chk_en = 1'b1;
        cyc(0, 0, z, z, 1, 0, 1);
        repeat (2) cyc(0, 0, z, z, 1, 0, 0);

        // Single FADD, already normalized
        a = '{sign: 1'b0, man: 49'h0_8000_0000_0000, exp: 9'h07F, tag: 5'd3};
        cyc(1, 0, a, z, 1, 0, 0);
        repeat (3) cyc(0, 0, z, z, 1, 0, 0);

        // Zero passes through
        m = '{sign: 1'b1, man: '0, exp: '0, tag: 5'd9};
        cyc(0, 1, z, m, 1, 0, 0);
        repeat (3) cyc(0, 0, z, z, 1, 0, 0);

        // Contention: alternating grants
        repeat (4) cyc(1, 1, rnd_op(), rnd_op(), 1, 0, 0);
        repeat (3) cyc(0, 0, z, z, 1, 0, 0);

        // Backpressure with both sides requesting, then release
        repeat (5) cyc(1, 1, rnd_op(), rnd_op(), 0, 0, 0);
        repeat (4) cyc(0, 0, z, z, 1, 0, 0);

        // Overflow, clear, then clear coincident with a second overflow capture
        m = '{sign: 1'b0, man: 49'h1_0000_0000_0000, exp: 9'h0FF, tag: 5'd7};
        cyc(0, 1, z, m, 1, 0, 0);
        repeat (2) cyc(0, 0, z, z, 1, 0, 0);
        cyc(0, 0, z, z, 1, 1, 0);
        cyc(0, 1, z, m, 1, 0, 0);
        cyc(0, 0, z, z, 1, 1, 0);
        repeat (2) cyc(0, 0, z, z, 1, 0, 0);
        cyc(0, 0, z, z, 1, 1, 0);

        // Reset mid-flight with both stages full
        cyc(1, 0, rnd_op(), z, 0, 0, 0);
        cyc(0, 1, z, rnd_op(), 0, 0, 0);
        cyc(1, 1, rnd_op(), rnd_op(), 0, 0, 0);
        cyc(1, 1, rnd_op(), rnd_op(), 1, 0, 1);
        repeat (3) cyc(0, 0, z, z, 1, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_op(), rnd_op(),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), 1'b0);
        end

        // Drain
        repeat (6) cyc(0, 0, z, z, 1, 0, 0);
        @(negedge clk);
        #3;
        chkw("sb_empty", 128'(sbq.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
